// File: rtl/store_ctrl_split_pkg.sv
// Shared definitions for the store-path controller.
//   state_e      controller states
//   cause codes  exception causes reported on the writeback
//   split_align  places a store into a double-word window (byte enables + data)
package store_ctrl_split_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_XLATE0 = 3'd1,
    ST_XLATE1 = 3'd2,
    ST_ISSUE0 = 3'd3,
    ST_ISSUE1 = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  localparam logic [3:0] ST_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] ST_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] STORE_PAGE_FAULT   = 4'd15;

  typedef struct packed {
    logic [15:0]  be;
    logic [127:0] data;
  } split_t;

  // Sized for the widest word (XLEN=64). A 32-bit controller uses only the
  // low 8 enable bits / 64 data bits, which hold the same values.
  function automatic split_t split_align(input logic [2:0]  offset,
                                         input logic [1:0]  size,
                                         input logic [63:0] data);
    split_t      r;
    logic [15:0] mask;
    case (size)
      2'd0:    mask = 16'h0001;
      2'd1:    mask = 16'h0003;
      2'd2:    mask = 16'h000F;
      default: mask = 16'h00FF;
    endcase
    r.be   = mask << offset;
    r.data = {64'd0, data} << {offset, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/store_ctrl_split_amo_credit_counter.sv
// Counts AMOs issued but not yet completed.
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         AMO handshake this cycle
//   dec_i         one AMO completed (ignored when the count is zero)
//   busy_o        count != 0
//   full_o        count == MAX
module store_ctrl_split_amo_credit_counter #(
  parameter int MAX = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic busy_o,
  output logic full_o
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] count_q;
  logic          dec_eff;

  assign dec_eff = dec_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && !dec_eff) begin
      if (count_q != CW'(MAX)) count_q <= count_q + 1'b1;
    end else if (!inc_i && dec_eff) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign busy_o = (count_q != '0);
  assign full_o = (count_q == CW'(MAX));

endmodule

// File: rtl/store_ctrl_split.sv
// Store/AMO path controller: accepts a request, translates one or two beats
// (a store crossing a word boundary becomes two aligned beats, both translated
// before either is issued), issues beats over valid/ready and returns one
// writeback with an optional exception.
//   request    valid_i/pop_o, vaddr_i, data_i, size_i, is_amo_i, amo_op_i, trans_id_i
//   translate  translation_req_o, vaddr_o, dtlb_hit_i, paddr_i, xlate_ex_i, xlate_ex_cause_i
//   beats      st_valid_o, amo_valid_o, beat_ready_i, beat_paddr/data/be/size_o, amo_op_o
//   AMO        amo_done_i, amo_busy_o
//   writeback  wb_valid_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o, wb_ex_tval_o
module store_ctrl_split
  import store_ctrl_split_pkg::*;
#(
  parameter int XLEN                = 64,
  parameter int VLEN                = 39,
  parameter int PLEN                = 56,
  parameter int TRANS_ID_BITS       = 3,
  parameter int SPLIT_EN            = 1,
  parameter int AMO_MAX_OUTSTANDING = 2,
  parameter int AMO_OP_W            = 4,
  localparam int NB                 = XLEN / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     pop_o,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [1:0]               size_i,
  input  logic                     is_amo_i,
  input  logic [AMO_OP_W-1:0]      amo_op_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [VLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     xlate_ex_i,
  output logic                     st_valid_o,
  output logic                     amo_valid_o,
  input  logic                     beat_ready_i,
  output logic [PLEN-1:0]          beat_paddr_o,
  output logic [XLEN-1:0]          beat_data_o,
  output logic [NB-1:0]            beat_be_o,
  output logic [1:0]               beat_size_o,
  output logic [AMO_OP_W-1:0]      amo_op_o,
  input  logic                     amo_done_i,
  output logic                     amo_busy_o,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_ex_valid_o,
  output logic [3:0]               wb_ex_cause_o,
  output logic [VLEN-1:0]          wb_ex_tval_o,
  input  logic [3:0]               xlate_ex_cause_i
);

  localparam int OFF_W = $clog2(NB);

  state_e state_q, state_d;

  // Incoming request geometry
  logic [OFF_W-1:0] in_off;
  logic [4:0]       in_nbytes, in_end;
  logic [2:0]       in_mask;
  logic             in_cross, in_size_ill, in_amo_mis, in_mis;

  assign in_off    = vaddr_i[OFF_W-1:0];
  assign in_nbytes = 5'd1 << size_i;
  assign in_end    = 5'(in_off) + in_nbytes;
  assign in_cross  = in_end > 5'(NB);

  always_comb begin
    case (size_i)
      2'd0:    in_mask = 3'd0;
      2'd1:    in_mask = 3'd1;
      2'd2:    in_mask = 3'd3;
      default: in_mask = 3'd7;
    endcase
  end

  assign in_size_ill = (XLEN == 32) && (size_i == 2'd3);
  assign in_amo_mis  = (vaddr_i[2:0] & in_mask) != 3'd0;
  assign in_mis      = in_size_ill ||
                       (is_amo_i ? in_amo_mis : (in_cross && (SPLIT_EN == 0)));

  // Latched request
  logic [VLEN-1:0]          vaddr_q;
  logic [XLEN-1:0]          data_q;
  logic [1:0]               size_q;
  logic                     amo_q, cross_q;
  logic [AMO_OP_W-1:0]      amo_op_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [PLEN-1:0]          paddr0_q, paddr1_q;
  logic                     ex_q;
  logic [3:0]               cause_q;
  logic [VLEN-1:0]          tval_q;

  logic [VLEN-1:0] vaddr1;
  split_t          sa;

  assign vaddr1 = {vaddr_q[VLEN-1:OFF_W], {OFF_W{1'b0}}} + VLEN'(NB);
  assign sa     = split_align(3'(vaddr_q[OFF_W-1:0]), size_q, 64'(data_q));

  logic accept, hs, amo_full;

  assign accept = ((state_q == ST_IDLE) || (state_q == ST_WB)) && valid_i && !flush_i;
  assign hs     = (st_valid_o || amo_valid_o) && beat_ready_i;

  store_ctrl_split_amo_credit_counter #(
    .MAX (AMO_MAX_OUTSTANDING)
  ) u_amo_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (amo_valid_o && beat_ready_i),
    .dec_i  (amo_done_i),
    .busy_o (amo_busy_o),
    .full_o (amo_full)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WB: begin
        if (accept) state_d = in_mis ? ST_WB : ST_XLATE0;
        else        state_d = ST_IDLE;
      end
      ST_XLATE0: begin
        if (xlate_ex_i)      state_d = ST_WB;
        else if (dtlb_hit_i) state_d = cross_q ? ST_XLATE1 : ST_ISSUE0;
      end
      ST_XLATE1: begin
        if (xlate_ex_i)      state_d = ST_WB;
        else if (dtlb_hit_i) state_d = ST_ISSUE0;
      end
      ST_ISSUE0: if (hs) state_d = cross_q ? ST_ISSUE1 : ST_WB;
      ST_ISSUE1: if (hs) state_d = ST_WB;
      default:   state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Outputs
  always_comb begin
    pop_o             = accept;
    translation_req_o = 1'b0;
    vaddr_o           = '0;
    st_valid_o        = 1'b0;
    amo_valid_o       = 1'b0;
    beat_paddr_o      = '0;
    beat_data_o       = '0;
    beat_be_o         = '0;
    beat_size_o       = 2'd0;
    amo_op_o          = '0;
    wb_valid_o        = 1'b0;
    wb_trans_id_o     = '0;
    wb_ex_valid_o     = 1'b0;
    wb_ex_cause_o     = 4'd0;
    wb_ex_tval_o      = '0;
    case (state_q)
      ST_XLATE0: begin
        translation_req_o = 1'b1;
        vaddr_o           = vaddr_q;
      end
      ST_XLATE1: begin
        translation_req_o = 1'b1;
        vaddr_o           = vaddr1;
      end
      ST_ISSUE0: begin
        st_valid_o   = !amo_q && !flush_i;
        amo_valid_o  = amo_q && !amo_full && !flush_i;
        beat_paddr_o = cross_q ? {paddr0_q[PLEN-1:OFF_W], {OFF_W{1'b0}}} : paddr0_q;
        beat_data_o  = amo_q ? data_q : sa.data[XLEN-1:0];
        beat_be_o    = sa.be[NB-1:0];
        beat_size_o  = cross_q ? 2'(OFF_W) : size_q;
        amo_op_o     = amo_q ? amo_op_q : '0;
      end
      ST_ISSUE1: begin
        st_valid_o   = !flush_i;
        beat_paddr_o = paddr1_q;
        beat_data_o  = sa.data[2*XLEN-1:XLEN];
        beat_be_o    = sa.be[2*NB-1:NB];
        beat_size_o  = 2'(OFF_W);
      end
      ST_WB: begin
        wb_valid_o    = !flush_i;
        wb_trans_id_o = id_q;
        wb_ex_valid_o = ex_q;
        wb_ex_cause_o = cause_q;
        wb_ex_tval_o  = tval_q;
      end
      default: ;
    endcase
  end

  // Request / translation / exception capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vaddr_q  <= '0;
      data_q   <= '0;
      size_q   <= 2'd0;
      amo_q    <= 1'b0;
      cross_q  <= 1'b0;
      amo_op_q <= '0;
      id_q     <= '0;
      paddr0_q <= '0;
      paddr1_q <= '0;
      ex_q     <= 1'b0;
      cause_q  <= 4'd0;
      tval_q   <= '0;
    end else if (accept) begin
      vaddr_q  <= vaddr_i;
      data_q   <= data_i;
      size_q   <= size_i;
      amo_q    <= is_amo_i;
      cross_q  <= in_cross && !is_amo_i;
      amo_op_q <= amo_op_i;
      id_q     <= trans_id_i;
      ex_q     <= in_mis;
      cause_q  <= ST_ADDR_MISALIGNED;
      tval_q   <= vaddr_i;
    end else if (!flush_i && (state_q == ST_XLATE0 || state_q == ST_XLATE1)) begin
      if (xlate_ex_i) begin
        ex_q    <= 1'b1;
        cause_q <= xlate_ex_cause_i;
        tval_q  <= (state_q == ST_XLATE0) ? vaddr_q : vaddr1;
      end else if (dtlb_hit_i) begin
        if (state_q == ST_XLATE0) paddr0_q <= paddr_i;
        else                      paddr1_q <= paddr_i;
      end
    end
  end

endmodule

// File: tb/tb_store_ctrl_split.sv
module tb_store_ctrl_split;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, is_amo_i, dtlb_hit_i, xlate_ex_i;
  logic        beat_ready_i, amo_done_i;
  logic [38:0] vaddr_i;
  logic [63:0] data_i;
  logic [1:0]  size_i;
  logic [3:0]  amo_op_i, xlate_ex_cause_i;
  logic [2:0]  trans_id_i;
  logic [55:0] paddr_i;

  logic        pop_o, translation_req_o, st_valid_o, amo_valid_o, amo_busy_o;
  logic        wb_valid_o, wb_ex_valid_o;
  logic [38:0] vaddr_o, wb_ex_tval_o;
  logic [55:0] beat_paddr_o;
  logic [63:0] beat_data_o;
  logic [7:0]  beat_be_o;
  logic [1:0]  beat_size_o;
  logic [3:0]  amo_op_o, wb_ex_cause_o;
  logic [2:0]  wb_trans_id_o;

  logic        ns_pop, ns_treq, ns_st_valid, ns_amo_valid, ns_amo_busy;
  logic        ns_wb_valid, ns_wb_ex_valid;
  logic [38:0] ns_vaddr, ns_wb_ex_tval;
  logic [55:0] ns_beat_paddr;
  logic [63:0] ns_beat_data;
  logic [7:0]  ns_beat_be;
  logic [1:0]  ns_beat_size;
  logic [3:0]  ns_amo_op, ns_wb_ex_cause;
  logic [2:0]  ns_wb_trans_id;

  int n_checks = 0;
  int n_fail   = 0;
  int st_seen  = 0;
  int st_before;

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (st_valid_o) st_seen++;

  store_ctrl_split dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .pop_o(pop_o),
    .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .is_amo_i(is_amo_i),
    .amo_op_i(amo_op_i), .trans_id_i(trans_id_i), .translation_req_o(translation_req_o),
    .vaddr_o(vaddr_o), .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .xlate_ex_i(xlate_ex_i),
    .st_valid_o(st_valid_o), .amo_valid_o(amo_valid_o), .beat_ready_i(beat_ready_i),
    .beat_paddr_o(beat_paddr_o), .beat_data_o(beat_data_o), .beat_be_o(beat_be_o),
    .beat_size_o(beat_size_o), .amo_op_o(amo_op_o), .amo_done_i(amo_done_i),
    .amo_busy_o(amo_busy_o), .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
    .wb_ex_tval_o(wb_ex_tval_o), .xlate_ex_cause_i(xlate_ex_cause_i)
  );

  store_ctrl_split #(.SPLIT_EN(0)) dut_ns (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .pop_o(ns_pop),
    .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .is_amo_i(is_amo_i),
    .amo_op_i(amo_op_i), .trans_id_i(trans_id_i), .translation_req_o(ns_treq),
    .vaddr_o(ns_vaddr), .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .xlate_ex_i(xlate_ex_i),
    .st_valid_o(ns_st_valid), .amo_valid_o(ns_amo_valid), .beat_ready_i(beat_ready_i),
    .beat_paddr_o(ns_beat_paddr), .beat_data_o(ns_beat_data), .beat_be_o(ns_beat_be),
    .beat_size_o(ns_beat_size), .amo_op_o(ns_amo_op), .amo_done_i(amo_done_i),
    .amo_busy_o(ns_amo_busy), .wb_valid_o(ns_wb_valid), .wb_trans_id_o(ns_wb_trans_id),
    .wb_ex_valid_o(ns_wb_ex_valid), .wb_ex_cause_o(ns_wb_ex_cause),
    .wb_ex_tval_o(ns_wb_ex_tval), .xlate_ex_cause_i(xlate_ex_cause_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one cycle; returns one cycle after acceptance.
  task automatic send(input logic [38:0] va, input logic [63:0] d, input logic [1:0] sz,
                      input logic amo, input logic [2:0] id);
    valid_i = 1'b1; vaddr_i = va; data_i = d; size_i = sz; is_amo_i = amo;
    amo_op_i = amo ? 4'h2 : 4'h0; trans_id_i = id;
    #1;
    check("pop", pop_o, 1'b1);
    tick();
    valid_i = 1'b0; is_amo_i = 1'b0;
  endtask

  // AMOADD.D: accept and translate; returns in ISSUE0.
  task automatic amo_to_issue(input logic [38:0] va, input logic [2:0] id);
    send(va, 64'h0000_0000_0000_00AB, 2'd3, 1'b1, id);
    dtlb_hit_i = 1'b1; paddr_i = {17'd0, va};
    tick();
    dtlb_hit_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 0; valid_i = 0; is_amo_i = 0; dtlb_hit_i = 0; xlate_ex_i = 0;
    beat_ready_i = 0; amo_done_i = 0; vaddr_i = '0; data_i = '0; size_i = 0;
    amo_op_i = 0; xlate_ex_cause_i = 0; trans_id_i = 0; paddr_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("rst treq", translation_req_o, 0);
    check("rst st_valid", st_valid_o, 0);
    check("rst wb_valid", wb_valid_o, 0);
    check("rst busy", amo_busy_o, 0);

    // Aligned SD, one beat, wb at T+3
    send(39'h1000, 64'h1122334455667788, 2'd3, 1'b0, 3'd1);
    dtlb_hit_i = 1'b1; paddr_i = 56'h8000_1000;
    #1;
    check("sd treq", translation_req_o, 1);
    check("sd vaddr_o", vaddr_o, 39'h1000);
    tick();
    dtlb_hit_i = 1'b0; beat_ready_i = 1'b1;
    #1;
    check("sd st_valid", st_valid_o, 1);
    check("sd paddr", beat_paddr_o, 56'h8000_1000);
    check("sd be", beat_be_o, 8'hFF);
    check("sd data", beat_data_o, 64'h1122334455667788);
    check("sd size", beat_size_o, 2'd3);
    tick();
    beat_ready_i = 1'b0;
    #1;
    check("sd wb", wb_valid_o, 1);
    check("sd wb id", wb_trans_id_o, 3'd1);
    check("sd wb ex", wb_ex_valid_o, 0);
    check("sd st after", st_valid_o, 0);
    tick();
    check("sd wb pulse", wb_valid_o, 0);

    // Split SW at 0x1006, wb at T+5
    send(39'h1006, 64'hAABBCCDD, 2'd2, 1'b0, 3'd2);
    dtlb_hit_i = 1'b1; paddr_i = 56'h8000_1006;
    #1;
    check("sw vaddr0", vaddr_o, 39'h1006);
    tick();
    paddr_i = 56'h8000_1008;
    #1;
    check("sw treq1", translation_req_o, 1);
    check("sw vaddr1", vaddr_o, 39'h1008);
    check("sw no beat yet", st_valid_o, 0);
    tick();
    dtlb_hit_i = 1'b0; beat_ready_i = 1'b1;
    #1;
    check("sw b0 valid", st_valid_o, 1);
    check("sw b0 paddr", beat_paddr_o, 56'h8000_1000);
    check("sw b0 be", beat_be_o, 8'hC0);
    check("sw b0 data", beat_data_o, 64'hCCDD_0000_0000_0000);
    check("sw b0 size", beat_size_o, 2'd3);
    tick();
    #1;
    check("sw b1 valid", st_valid_o, 1);
    check("sw b1 paddr", beat_paddr_o, 56'h8000_1008);
    check("sw b1 be", beat_be_o, 8'h03);
    check("sw b1 data", beat_data_o, 64'hAABB);
    tick();
    beat_ready_i = 1'b0;
    #1;
    check("sw wb", wb_valid_o, 1);
    check("sw wb ex", wb_ex_valid_o, 0);
    tick();

    // Split SW, page fault on beat1 (fault wins over a simultaneous hit)
    st_before = st_seen;
    send(39'h1006, 64'hAABBCCDD, 2'd2, 1'b0, 3'd3);
    dtlb_hit_i = 1'b1; paddr_i = 56'h8000_1006;
    tick();
    xlate_ex_i = 1'b1; xlate_ex_cause_i = 4'd15;
    tick();
    xlate_ex_i = 1'b0; dtlb_hit_i = 1'b0; beat_ready_i = 1'b1;
    #1;
    check("pf wb", wb_valid_o, 1);
    check("pf ex", wb_ex_valid_o, 1);
    check("pf cause", wb_ex_cause_o, 4'd15);
    check("pf tval", wb_ex_tval_o, 39'h1008);
    check("pf id", wb_trans_id_o, 3'd3);
    tick();
    tick();
    beat_ready_i = 1'b0;
    check("pf no beat", st_seen - st_before, 0);

    // SPLIT_EN=0 misaligned; reset the split instance mid-XLATE0
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    send(39'h1006, 64'hAABBCCDD, 2'd2, 1'b0, 3'd4);
    #1;
    check("ns wb", ns_wb_valid, 1);
    check("ns treq", ns_treq, 0);
    check("ns ex", ns_wb_ex_valid, 1);
    check("ns cause", ns_wb_ex_cause, 4'd6);
    check("ns tval", ns_wb_ex_tval, 39'h1006);
    check("mid xlate0", translation_req_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst2 treq", translation_req_o, 0);
    check("rst2 vaddr_o", vaddr_o, 39'h0);
    check("rst2 wb", wb_valid_o, 0);
    check("rst2 st", st_valid_o, 0);
    check("rst2 ns wb", ns_wb_valid, 0);

    // Misaligned AMO -> immediate WB cause 6
    send(39'h2004, 64'h1, 2'd3, 1'b1, 3'd5);
    #1;
    check("amo mis wb", wb_valid_o, 1);
    check("amo mis cause", wb_ex_cause_o, 4'd6);
    check("amo mis treq", translation_req_o, 0);
    tick();

    // AMO credit gating
    amo_to_issue(39'h2000, 3'd1);
    beat_ready_i = 1'b1;
    #1;
    check("amo1 valid", amo_valid_o, 1);
    check("amo1 st", st_valid_o, 0);
    check("amo1 data", beat_data_o, 64'hAB);
    check("amo1 op", amo_op_o, 4'h2);
    tick(); beat_ready_i = 1'b0; tick();
    check("amo1 busy", amo_busy_o, 1);
    amo_to_issue(39'h2008, 3'd2);
    beat_ready_i = 1'b1;
    #1;
    check("amo2 valid", amo_valid_o, 1);
    tick(); beat_ready_i = 1'b0; tick();
    amo_to_issue(39'h2010, 3'd3);
    beat_ready_i = 1'b1;
    #1;
    check("amo3 held", amo_valid_o, 0);
    tick();
    check("amo3 still held", amo_valid_o, 0);
    check("amo3 no wb", wb_valid_o, 0);
    check("amo busy full", amo_busy_o, 1);
    amo_done_i = 1'b1;
    #1;
    check("amo3 held on done", amo_valid_o, 0);
    tick();
    amo_done_i = 1'b0;
    #1;
    check("amo3 issued", amo_valid_o, 1);
    tick();
    beat_ready_i = 1'b0;
    check("amo3 wb", wb_valid_o, 1);
    check("amo3 wb id", wb_trans_id_o, 3'd3);
    tick();
    check("amo busy 2", amo_busy_o, 1);
    amo_done_i = 1'b1; tick(); tick(); amo_done_i = 1'b0;
    check("amo drained", amo_busy_o, 0);
    amo_done_i = 1'b1; tick(); amo_done_i = 1'b0;
    check("amo done at 0", amo_busy_o, 0);
    amo_to_issue(39'h2018, 3'd4);
    beat_ready_i = 1'b1;
    tick();
    beat_ready_i = 1'b0;
    check("amo4 busy", amo_busy_o, 1);
    tick();
    amo_done_i = 1'b1; tick(); amo_done_i = 1'b0;
    check("amo4 drained", amo_busy_o, 0);

    // Flush while beat1 is stalled
    send(39'h1006, 64'hAABBCCDD, 2'd2, 1'b0, 3'd6);
    dtlb_hit_i = 1'b1; paddr_i = 56'h8000_1006;
    tick();
    paddr_i = 56'h8000_1008;
    tick();
    dtlb_hit_i = 1'b0; beat_ready_i = 1'b1;
    tick();
    beat_ready_i = 1'b0;
    #1;
    check("fl b1 valid", st_valid_o, 1);
    tick();
    check("fl b1 hold", st_valid_o, 1);
    check("fl b1 be hold", beat_be_o, 8'h03);
    flush_i = 1'b1;
    #1;
    check("fl st forced", st_valid_o, 0);
    tick();
    flush_i = 1'b0; beat_ready_i = 1'b1;
    #1;
    check("fl idle st", st_valid_o, 0);
    check("fl idle treq", translation_req_o, 0);
    check("fl no wb", wb_valid_o, 0);
    tick();
    beat_ready_i = 1'b0;
    check("fl no wb later", wb_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
